// File: rtl/header_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : header_rx_framer
//  Description : Frames the UART receive byte stream into fixed-size block
//                headers. Bytes are shifted in MSB-first; a complete header
//                is held under a valid/ack handshake. Partial frames that
//                stall longer than TIMEOUT_CYCLES are discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module header_rx_framer #(
    parameter int HEADER_BYTES   = 80,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [7:0]                        rx,
    input  logic                              rxce,
    input  logic                              header_ack,
    output logic [8*HEADER_BYTES-1:0]         header,
    output logic                              header_valid,
    output logic [$clog2(HEADER_BYTES+1)-1:0] byte_count,
    output logic                              timeout,
    output logic                              overrun
);

    localparam int c_HDR_W = 8 * HEADER_BYTES;
    localparam int c_BC_W  = $clog2(HEADER_BYTES + 1);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_BC_W-1:0]  c_BC_FULL = c_BC_W'(HEADER_BYTES);
    localparam logic [c_BC_W-1:0]  c_BC_ONE  = c_BC_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t               r_state_q,      w_state_d;
    logic [c_HDR_W-1:0]   r_header_q,     w_header_d;
    logic [c_BC_W-1:0]    r_byte_count_q, w_byte_count_d;
    logic [c_CNT_W-1:0]   r_idle_cnt_q,   w_idle_cnt_d;
    logic                 r_timeout_q,    w_timeout_d;
    logic                 r_overrun_q,    w_overrun_d;

    logic [c_BC_W-1:0]    w_bc_inc;

    assign w_bc_inc = r_byte_count_q + c_BC_ONE;

    // Next-state logic: byte capture, inter-byte timeout, and FULL handshake
    always_comb begin
        w_state_d      = r_state_q;
        w_header_d     = r_header_q;
        w_byte_count_d = r_byte_count_q;
        w_idle_cnt_d   = '0;
        w_timeout_d    = 1'b0;
        w_overrun_d    = r_overrun_q;

        case (r_state_q)
            S_IDLE, S_FILL: begin
                if (rxce) begin
                    // A byte always beats an expiring counter
                    w_header_d     = {r_header_q[c_HDR_W-9:0], rx};
                    w_byte_count_d = w_bc_inc;
                    w_idle_cnt_d   = '0;
                    w_state_d      = (w_bc_inc == c_BC_FULL) ? S_FULL : S_FILL;
                end else if (r_state_q == S_FILL) begin
                    if (r_idle_cnt_q == c_CNT_MAX) begin
                        // Stalled partial frame: drop it, leave header as is
                        w_state_d      = S_IDLE;
                        w_byte_count_d = '0;
                        w_idle_cnt_d   = '0;
                        w_timeout_d    = 1'b1;
                    end else begin
                        w_idle_cnt_d = r_idle_cnt_q + c_CNT_ONE;
                    end
                end
            end
            S_FULL: begin
                // Header frozen; any byte arriving now is lost
                if (rxce) begin
                    w_overrun_d = 1'b1;
                end
                if (header_ack) begin
                    w_state_d      = S_IDLE;
                    w_byte_count_d = '0;
                end
            end
            default: begin
                w_state_d      = S_IDLE;
                w_byte_count_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q      <= S_IDLE;
            r_header_q     <= '0;
            r_byte_count_q <= '0;
            r_idle_cnt_q   <= '0;
            r_timeout_q    <= 1'b0;
            r_overrun_q    <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_header_q     <= w_header_d;
            r_byte_count_q <= w_byte_count_d;
            r_idle_cnt_q   <= w_idle_cnt_d;
            r_timeout_q    <= w_timeout_d;
            r_overrun_q    <= w_overrun_d;
        end
    end

    assign header       = r_header_q;
    assign header_valid = (r_state_q == S_FULL);
    assign byte_count   = r_byte_count_q;
    assign timeout      = r_timeout_q;
    assign overrun      = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_header_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_header_rx_framer
//  Description : Self-checking bench for header_rx_framer. A byte-list model
//                builds expected headers, queued when a frame completes and
//                popped when the DUT presents header_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_header_rx_framer;

    localparam int HB = 80;
    localparam int TO = 100;
    localparam int HW = 8 * HB;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic [7:0]    rx         = 8'h00;
    logic          rxce       = 1'b0;
    logic          header_ack = 1'b0;
    logic [HW-1:0] header;
    logic          header_valid;
    logic [6:0]    byte_count;
    logic          timeout;
    logic          overrun;

    header_rx_framer #(
        .HEADER_BYTES   (HB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .rxce         (rxce),
        .header_ack   (header_ack),
        .header       (header),
        .header_valid (header_valid),
        .byte_count   (byte_count),
        .timeout      (timeout),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    // Edge counter and timeout pulse monitor
    int cyc = 0;
    int n_to = 0;
    int last_to_edge = -1;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) begin
        if (timeout === 1'b1) begin
            n_to         = n_to + 1;
            last_to_edge = cyc;
        end
    end

    // Model state
    logic [7:0]    m_bytes[$];
    logic [HW-1:0] exp_q[$];
    logic [HW-1:0] cur_hdr;
    logic [HW-1:0] exp_h;
    bit            m_full    = 1'b0;
    bit            m_overrun = 1'b0;
    int            last_edge = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [HW-1:0] pack_bytes();
        logic [HW-1:0] h;
        h = '0;
        for (int i = 0; i < m_bytes.size(); i++) h[HW-1-8*i -: 8] = m_bytes[i];
        return h;
    endfunction

    task automatic model_clear();
        m_bytes.delete();
        m_full = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx   = b;
        rxce = 1'b1;
        tick();
        rxce      = 1'b0;
        last_edge = cyc;
        if (m_full) begin
            m_overrun = 1'b1;
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == HB) begin
                exp_q.push_back(pack_bytes());
                m_full = 1'b1;
            end
        end
    endtask

    task automatic pulse_ack();
        header_ack = 1'b1;
        tick();
        header_ack = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_clear();
        exp_q.delete();
        m_overrun = 1'b0;
        n_tests += 5;
        if (header !== '0) begin n_fail++; $display("FAIL rst_header: got %h exp 0", header); end
        if (header_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", header_valid); end
        if (byte_count !== 7'd0) begin n_fail++; $display("FAIL rst_count: got %0d exp 0", byte_count); end
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %b exp 0", timeout); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b exp 0", overrun); end
    endtask

    task automatic test_basic();
        int bad;
        for (int i = 0; i < HB; i++) begin
            send_byte(8'(i));
            if (i != HB - 1) idle(9);
        end
        n_tests += 4;
        if (header_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b exp 1", header_valid); end
        if (byte_count !== 7'd80) begin n_fail++; $display("FAIL basic_count: got %0d exp 80", byte_count); end
        if (header[639:632] !== 8'h00 || header[7:0] !== 8'h4F) begin
            n_fail++; $display("FAIL basic_ends: got first %h last %h exp 00 4f", header[639:632], header[7:0]);
        end
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL basic_hdr: got no queued header exp one");
        end else begin
            cur_hdr = exp_q.pop_front();
            if (header !== cur_hdr) begin n_fail++; $display("FAIL basic_hdr: got %h exp %h", header, cur_hdr); end
        end
        bad = 0;
        repeat (1000) begin
            tick();
            if (header !== cur_hdr || header_valid !== 1'b1 || byte_count !== 7'd80) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL basic_hold: got %0d unstable cycles exp 0", bad); end
    endtask

    task automatic test_ack_second();
        pulse_ack();
        n_tests += 2;
        if (header_valid !== 1'b0) begin n_fail++; $display("FAIL ack_valid: got %b exp 0", header_valid); end
        if (byte_count !== 7'd0) begin n_fail++; $display("FAIL ack_count: got %0d exp 0", byte_count); end
        for (int i = 0; i < HB; i++) send_byte(8'hA0);
        n_tests += 2;
        if (header_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b exp 1", header_valid); end
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL b2b_hdr: got no queued header exp one");
        end else begin
            cur_hdr = exp_q.pop_front();
            if (header !== cur_hdr) begin n_fail++; $display("FAIL b2b_hdr: got %h exp %h", header, cur_hdr); end
        end
    endtask

    task automatic test_timeout();
        int base;
        int exp_edge;
        pulse_ack();
        base = n_to;
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
        exp_edge = last_edge + TO + 1;
        idle(150);
        model_clear();
        n_tests += 3;
        if (n_to - base != 1) begin n_fail++; $display("FAIL to_count: got %0d pulses exp 1", n_to - base); end
        if (last_to_edge != exp_edge) begin n_fail++; $display("FAIL to_time: got edge %0d exp %0d", last_to_edge, exp_edge); end
        if (byte_count !== 7'd0) begin n_fail++; $display("FAIL to_bcount: got %0d exp 0", byte_count); end
        for (int i = 0; i < HB; i++) send_byte(8'h30 + 8'(i));
        n_tests += 2;
        if (header_valid !== 1'b1) begin n_fail++; $display("FAIL to_valid: got %b exp 1", header_valid); end
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL to_hdr: got no queued header exp one");
        end else begin
            cur_hdr = exp_q.pop_front();
            if (header !== cur_hdr) begin n_fail++; $display("FAIL to_hdr: got %h exp %h", header, cur_hdr); end
        end
    endtask

    task automatic test_overrun();
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %b exp 0", overrun); end
        send_byte(8'hEE);
        n_tests += 4;
        if (header !== cur_hdr) begin n_fail++; $display("FAIL ovr_hdr: got %h exp %h", header, cur_hdr); end
        if (overrun !== m_overrun) begin n_fail++; $display("FAIL ovr_flag: got %b exp %b", overrun, m_overrun); end
        if (byte_count !== 7'd80) begin n_fail++; $display("FAIL ovr_count: got %0d exp 80", byte_count); end
        if (header_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b exp 1", header_valid); end
        // byte and ack in the same cycle
        header_ack = 1'b1;
        send_byte(8'h77);
        header_ack = 1'b0;
        model_clear();
        n_tests += 3;
        if (header_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_valid: got %b exp 0", header_valid); end
        if (byte_count !== 7'd0) begin n_fail++; $display("FAIL ovr_ack_count: got %0d exp 0", byte_count); end
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b exp 1", overrun); end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 40; i++) send_byte(8'h99);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        exp_q.delete();
        m_overrun = 1'b0;
        n_tests += 5;
        if (header !== '0) begin n_fail++; $display("FAIL mrst_header: got %h exp 0", header); end
        if (header_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b exp 0", header_valid); end
        if (byte_count !== 7'd0) begin n_fail++; $display("FAIL mrst_count: got %0d exp 0", byte_count); end
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL mrst_timeout: got %b exp 0", timeout); end
        if (overrun !== m_overrun) begin n_fail++; $display("FAIL mrst_overrun: got %b exp %b", overrun, m_overrun); end
        for (int i = 0; i < HB; i++) send_byte(8'h55);
        n_tests += 2;
        if (header_valid !== 1'b1) begin n_fail++; $display("FAIL mrst_fvalid: got %b exp 1", header_valid); end
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL mrst_hdr: got no queued header exp one");
        end else begin
            cur_hdr = exp_q.pop_front();
            if (header !== cur_hdr) begin n_fail++; $display("FAIL mrst_hdr: got %h exp %h", header, cur_hdr); end
        end
    endtask

    task automatic test_near_expiry();
        int base;
        pulse_ack();
        base = n_to;
        send_byte(8'hC0);
        // ack outside FULL must be ignored; counter reaches its limit
        header_ack = 1'b1;
        idle(TO);
        header_ack = 1'b0;
        n_tests += 2;
        if (byte_count !== 7'd1) begin n_fail++; $display("FAIL ne_count: got %0d exp 1", byte_count); end
        if (n_to != base) begin n_fail++; $display("FAIL ne_early_to: got %0d pulses exp 0", n_to - base); end
        for (int i = 1; i < HB; i++) send_byte(8'hC0 + 8'(i));
        idle(TO + 5);
        n_tests += 4;
        if (n_to != base) begin n_fail++; $display("FAIL ne_to: got %0d pulses exp 0", n_to - base); end
        if (header_valid !== 1'b1) begin n_fail++; $display("FAIL ne_valid: got %b exp 1", header_valid); end
        if (byte_count !== 7'd80) begin n_fail++; $display("FAIL ne_fcount: got %0d exp 80", byte_count); end
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL ne_hdr: got no queued header exp one");
        end else begin
            cur_hdr = exp_q.pop_front();
            if (header !== cur_hdr) begin n_fail++; $display("FAIL ne_hdr: got %h exp %h", header, cur_hdr); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_second();
        test_timeout();
        test_overrun();
        test_reset_midframe();
        test_near_expiry();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/header_rx_framer.md
# header_rx_framer

Frames the raw UART receive byte stream into complete 80-byte block headers for the hashing core. Sits directly downstream of the UART receiver (`rx` byte, `rxce` strobe). Collects exactly `HEADER_BYTES` bytes into a 640-bit header and presents it to the miner with a valid/ack handshake. Drops stalled partial frames after an inter-byte timeout, so a lost byte cannot permanently misalign later headers.

## Interface
- `HEADER_BYTES`, 80: bytes per frame; header width is 8*HEADER_BYTES.
- `TIMEOUT_CYCLES`, 500000: idle cycles allowed between bytes of one frame (10 ms at 50 MHz).
- `clock` in 1: single clock; everything is on posedge.
- `reset` in 1: synchronous, active-high.
- `rx` in 8: received byte; valid only when `rxce`=1.
- `rxce` in 1: one-cycle strobe, one per received byte.
- `header_ack` in 1: consumer has taken `header`. Ignored unless `header_valid`=1.
- `header` out 8*HEADER_BYTES: assembled header. The first received byte is in `[8*HEADER_BYTES-1 -: 8]`; the last byte is in `[7:0]`.
- `header_valid` out 1: a complete header is held.
- `byte_count` out 7 ($clog2(HEADER_BYTES+1)): bytes captured in the current frame.
- `timeout` out 1: one-cycle pulse when a partial frame is discarded.
- `overrun` out 1: sticky flag, set when a byte arrives while `header_valid`=1. Cleared only by reset.

## Operation
- States:
  - IDLE: `byte_count`=0.
  - FILL: 0<`byte_count`<HEADER_BYTES.
  - FULL: `header_valid`=1.
- Byte capture, in IDLE or FILL with `rxce`=1:
  - `header` <= {`header`[8*HEADER_BYTES-9:0], `rx`}.
  - `byte_count` increments.
  - Idle counter clears.
- IDLE -> FILL on the first byte.
- FILL -> FULL on the edge that captures byte HEADER_BYTES: `byte_count` becomes HEADER_BYTES and `header_valid` becomes 1 on that same edge.
- FILL, timeout path:
  - The idle counter increments on each cycle without `rxce`.
  - When it reaches TIMEOUT_CYCLES, the next edge returns to IDLE: `byte_count`=0, counter=0, `timeout`=1 for one cycle.
  - `header` is left unchanged.
- FULL:
  - `header` and `byte_count` are frozen.
  - `rxce` drops the byte and sets `overrun`.
  - `header_ack`=1 -> next edge goes to IDLE with `header_valid`=0 and `byte_count`=0.
- Simultaneous `rxce` and `header_ack` in FULL: the byte is dropped, `overrun` is set, and the ack still takes effect.
- `rxce` on the same cycle the counter would expire: the byte wins. It is captured, the counter clears, and no timeout occurs.
- The idle counter runs only in FILL. It is held at 0 in IDLE and FULL. Width is $clog2(TIMEOUT_CYCLES+1).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values:
  - `header`=0, `header_valid`=0, `byte_count`=0, `timeout`=0, `overrun`=0.
  - State IDLE, idle counter 0.
- Reset mid-frame or while FULL discards everything. The next `rxce` after reset is treated as byte 0.
- Latency: `header_valid` rises on the edge that samples the final `rxce`, so it is visible the following cycle.
- Ack: `header_valid` falls on the edge that samples `header_ack`=1. Back-to-back frames are accepted immediately after that edge.
- Throughput: one byte per clock is sustained, so `rxce` may be high on consecutive cycles.
- Timeout: with the last `rxce` sampled at edge N and no further `rxce`, `timeout` is high during the cycle after edge N+TIMEOUT_CYCLES+1.
- `header_ack` while `header_valid`=0 has no effect.

## Test plan
- Send bytes 0x00..0x4F (80 bytes, one every 10 cycles), then hold `header_ack`=0. Required:
  - `header_valid`=1 with `header`[639:632]=0x00 and `header`[7:0]=0x4F.
  - `byte_count`=80; stays stable for 1000 cycles.
- Pulse `header_ack` for one cycle, then send a second frame of 0xA0 repeated 80 times. Required:
  - `header_valid` goes 0 the next cycle and `byte_count`=0.
  - The second frame yields `header`=all 0xA0 and `header_valid`=1.
- With `TIMEOUT_CYCLES`=100, send 5 bytes, then idle for 150 cycles. Required:
  - exactly one `timeout` pulse about 101 cycles after the last byte;
  - `byte_count` returns to 0;
  - a following full frame is captured correctly aligned.
- With FULL held, send 1 byte, including a case where `rxce` and `header_ack` are on the same cycle. Required:
  - `header` unchanged;
  - `overrun`=1 and it stays 1 after ack;
  - `byte_count`=0 after ack.
- Assert `reset` for one cycle after 40 bytes, then send 80 bytes of 0x55. Required:
  - all outputs are at their reset values the cycle after reset;
  - the frame completes with `header`=all 0x55.
- Drive 80 consecutive-cycle `rxce` strobes with the counter 1 cycle from expiry. Required: no timeout, and `header_valid`=1 after byte 80.
